// File: rtl/mi_nios_pio_in_edge.sv
// mi_nios_pio_in_edge
// Avalon-MM parallel input port with edge capture and a maskable interrupt.
// The external bus passes through a synchroniser and an optional per-bit
// debounce filter. Selected edges of the filtered value latch into sticky
// EDGECAPTURE bits, which software clears by writing 1s.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     register select: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    registered read data, latency 1, updated every cycle
//   in_port     asynchronous external inputs
//   irq         interrupt request, |(EDGECAPTURE & IRQMASK)
module mi_nios_pio_in_edge #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] prev_q;          // filtered value delayed one cycle
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] clr_bits;
    logic [31:0]      rdata_q, rdata_d;
    logic             wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nofilt
            always_comb filt_d = sync;
        end else begin : g_filt
            localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q [WIDTH];
            logic [CW-1:0] cnt_d [WIDTH];

            // Counter tracks how long sync has disagreed with filt; any
            // agreement restarts it, so short glitches never propagate.
            always_comb begin
                filt_d = filt_q;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i] = '0;
                    if (sync[i] != filt_q[i]) begin
                        if (cnt_q[i] == CNT_LAST) filt_d[i] = sync[i];
                        else                      cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
                end
            end
        end

        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_hit = filt_q & ~prev_q;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_hit = ~filt_q & prev_q;
        end else begin : g_any
            assign edge_hit = filt_q ^ prev_q;
        end

        if (WIDTH < 32) begin : g_wdata_hi
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    assign wr_en    = chipselect & ~write_n;
    assign clr_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A new edge on a bit being cleared in the same cycle keeps the bit set.
    assign cap_d  = (cap_q & ~clr_bits) | edge_hit;
    assign mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;

    always_comb begin
        rdata_d = '0;
        case (address)
            2'd0:    rdata_d[WIDTH-1:0] = filt_q;
            2'd2:    rdata_d[WIDTH-1:0] = mask_q;
            2'd3:    rdata_d[WIDTH-1:0] = cap_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q  <= '0;
            prev_q  <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule
